// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one fifo_sync write port among NUM_REQ producers
module fifo_wr_arb #(
  parameter int MEMORY_WIDTH = 4,
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_SIZE = 2,
  parameter int BURST_MAX    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            FULL,
  output logic                            w_en,
  output logic [MEMORY_WIDTH-1:0]         WR,
  output logic [REQ_IDX_SIZE-1:0]         grant_idx,
  output logic                            busy
);
  typedef enum logic {IDLE, GNT} state_t;
  state_t                  state_q, state_d;
  logic [REQ_IDX_SIZE-1:0] owner_q, owner_d, last_q, last_d, sel, cand;
  logic [3:0]              beat_q, beat_d;
  logic                    found, xfer;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= REQ_IDX_SIZE'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end
  // first valid requester after the most recent grant, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = REQ_IDX_SIZE'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end
  // rst gating keeps a reset cycle inside a burst from writing
  assign xfer      = (state_q == GNT) && rst && req_valid[owner_q] && !FULL;
  assign w_en      = xfer;
  assign req_ready = xfer ? (NUM_REQ'(1) << owner_q) : '0;
  assign WR        = (state_q == GNT) ? req_data[owner_q*MEMORY_WIDTH +: MEMORY_WIDTH] : '0;
  assign grant_idx = owner_q;
  assign busy      = (state_q == GNT);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    if (state_q == IDLE) begin
      if (found && !FULL) begin
        state_d = GNT;
        owner_d = sel;
        last_d  = sel;
        beat_d  = '0;
      end
    end else if (!req_valid[owner_q]) begin
      state_d = IDLE;
    end else if (xfer) begin
      beat_d  = beat_q + 4'd1;
      state_d = (beat_q + 4'd1 == 4'(BURST_MAX)) ? IDLE : GNT;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus randomized traffic checked against a behavioural model
module tb_fifo_wr_arb;
  localparam int W = 4, N = 4, IW = 2, B = 2;
  logic clk = 1'b0, rst = 1'b0, full = 1'b0;
  logic [N-1:0] v = '0, rdy, acc = '0;
  logic [N*W-1:0] rd;
  logic [W-1:0] wr, pd[N];
  logic w_en, busy;
  logic [IW-1:0] gi;
  int n_chk = 0, n_pass = 0;
  bit m_busy = 1'b0;
  int m_owner = 0, m_last = N - 1, m_beats = 0;
  int wq_idx[$], wq_dat[$];
  int exp_idx[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  fifo_wr_arb #(.MEMORY_WIDTH(W), .NUM_REQ(N), .REQ_IDX_SIZE(IW), .BURST_MAX(B)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_data(rd), .req_ready(rdy),
    .FULL(full), .w_en(w_en), .WR(wr), .grant_idx(gi), .busy(busy));

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) rd[i*W +: W] = pd[i];

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // inputs are set at the falling edge; outputs checked 2ns later, model advances at the rising edge
  task automatic tick();
    bit x;
    int c;
    x = m_busy && rst && v[m_owner] && !full;
    #2;
    check("busy", busy, m_busy);
    check("grant_idx", gi, m_owner);
    check("w_en", w_en, x);
    check("req_ready", rdy, x ? (1 << m_owner) : 0);
    check("WR", wr, m_busy ? pd[m_owner] : 0);
    if (w_en) begin
      wq_idx.push_back(gi);
      wq_dat.push_back(wr);
    end
    acc = x ? N'(1 << m_owner) : '0;
    @(posedge clk);
    if (!rst) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_beats = 0;
    end else if (!m_busy) begin
      if (v != 0 && !full)
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (v[c]) begin
            m_busy = 1; m_owner = c; m_last = c; m_beats = 0;
            break;
          end
        end
    end else if (!v[m_owner]) m_busy = 0;
    else if (x) begin
      m_beats++;
      if (m_beats == B) m_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wq_idx.delete();
    wq_dat.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) pd[i] = W'(i + 9);
    v = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    v = 4'b0001; pd[0] = 4'd1;
    tick();
    tick();
    pd[0] = 4'd2;
    tick();
    v = '0;
    tick();
    check("single_idle_after", busy, 0);
    check("single_count", wq_dat.size(), 2);
    if (wq_dat.size() == 2) begin
      check("single_w0", wq_dat[0], 1);
      check("single_w1", wq_dat[1], 2);
      check("single_idx", wq_idx[1], 0);
    end

    do_reset();
    v = 4'b1111; full = 1'b0;
    for (int i = 0; i < N; i++) pd[i] = W'(i + 1);
    repeat (15) tick();
    check("rr_count", wq_idx.size(), 10);
    for (int i = 0; i < 10 && i < wq_idx.size(); i++) begin
      check("rr_idx", wq_idx[i], exp_idx[i]);
      check("rr_dat", wq_dat[i], exp_idx[i] + 1);
    end

    do_reset();
    v = 4'b0010; pd[1] = 4'd5;
    tick();
    tick();
    pd[1] = 4'd6; full = 1'b1;
    repeat (3) tick();
    check("stall_writes", wq_dat.size(), 1);
    full = 1'b0;
    tick();
    check("stall_count", wq_dat.size(), 2);
    if (wq_dat.size() == 2) check("stall_w1", wq_dat[1], 6);
    v = '0;
    tick();

    do_reset();
    v = 4'b0100; pd[2] = 4'd7;
    tick();
    tick();
    v = 4'b1001; pd[0] = 4'd1; pd[3] = 4'd3;
    tick();
    check("early_idle", busy, 0);
    check("early_last", gi, 2);
    tick();
    check("early_next_busy", busy, 1);
    check("early_next_idx", gi, 3);

    do_reset();
    full = 1'b1; v = 4'b1111;
    repeat (3) tick();
    check("full_idle_busy", busy, 0);
    full = 1'b0;
    tick();
    check("full_idle_grant", busy, 1);
    check("full_idle_idx", gi, 0);

    v = 4'b0100;
    tick();
    tick();
    check("midburst_busy", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_idx", gi, 0);
    v = 4'b0101;
    tick();
    check("rst_first_grant", gi, 0);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if (v[i] && !acc[i]) begin
          if ($urandom_range(9) == 0) v[i] = 1'b0;
        end else begin
          v[i] = $urandom_range(2) != 0;
          pd[i] = W'($urandom);
        end
      full = $urandom_range(3) == 0;
      rst = $urandom_range(59) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
